// File: rtl/rgb2raw.sv
// RGB-to-RAW8 re-mosaic: samples one Bayer component per pixel and packs
// PIX_PER_WORD samples per output word, lane 0 holding the earliest pixel.
`timescale 1ns/1ps
module rgb2raw #(
  parameter int LINE_LENGTH   = 640,
  parameter int RGB_WIDTH     = 24,
  parameter int PIX_PER_WORD  = 4,
  parameter int BAYER_PATTERN = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RGB_WIDTH-1:0]      rgb_in,
  input  logic                      rgb_valid,
  input  logic                      rgb_sof,
  output logic                      rgb_ready,
  output logic [8*PIX_PER_WORD-1:0] raw_out,
  output logic                      raw_valid,
  output logic                      raw_sof,
  output logic                      raw_eol,
  input  logic                      raw_ready,
  output logic                      frame_err
);

  localparam int XW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int IW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int OW = 8 * PIX_PER_WORD;
  localparam logic [XW-1:0] X_LAST   = XW'(LINE_LENGTH - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(PIX_PER_WORD - 1);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [1:0]    PHASE    = 2'(BAYER_PATTERN);
  localparam bit            ONE_LANE = (PIX_PER_WORD == 1);

  logic [XW-1:0] x_r;
  logic          row_r;
  logic [IW-1:0] pix_idx_r;
  logic [7:0]    pack_r [PIX_PER_WORD];
  logic          sof_pend_r;

  logic          accept_s;
  logic [XW-1:0] eff_x_s;
  logic          eff_row_s;
  logic [IW-1:0] eff_idx_s;
  logic [1:0]    phase_s;
  logic [7:0]    comp_s;
  logic [OW-1:0] word_s;

  // Only the word-completing pixel can be stalled by a held output word.
  assign rgb_ready = (pix_idx_r != IDX_LAST) || !raw_valid || raw_ready;
  assign accept_s  = rgb_valid && rgb_ready;

  // Effective position (sof restarts the frame), Bayer component select and word assembly.
  always_comb begin
    eff_x_s   = x_r;
    eff_row_s = row_r;
    eff_idx_s = pix_idx_r;
    if (rgb_sof) begin
      eff_x_s   = {XW{1'b0}};
      eff_row_s = 1'b0;
      eff_idx_s = IDX_ZERO;
    end else begin
      eff_x_s   = x_r;
      eff_row_s = row_r;
      eff_idx_s = pix_idx_r;
    end
    phase_s = {eff_row_s, eff_x_s[0]} ^ PHASE;
    case (phase_s)
      2'b00:        comp_s = rgb_in[23:16];
      2'b01, 2'b10: comp_s = rgb_in[15:8];
      2'b11:        comp_s = rgb_in[7:0];
      default:      comp_s = rgb_in[15:8];
    endcase
    word_s = {OW{1'b0}};
    for (int i = 0; i < PIX_PER_WORD - 1; i++) begin
      word_s[i*8 +: 8] = pack_r[i];
    end
    word_s[OW-1 -: 8] = comp_s;
  end

  // Counters, pack lanes, output word register and sticky frame error.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r        <= {XW{1'b0}};
      row_r      <= 1'b0;
      pix_idx_r  <= IDX_ZERO;
      sof_pend_r <= 1'b0;
      raw_out    <= {OW{1'b0}};
      raw_valid  <= 1'b0;
      raw_sof    <= 1'b0;
      raw_eol    <= 1'b0;
      frame_err  <= 1'b0;
      for (int i = 0; i < PIX_PER_WORD; i++) begin
        pack_r[i] <= 8'h00;
      end
    end else begin
      if (accept_s) begin
        if (rgb_sof && (pix_idx_r != IDX_ZERO)) begin
          frame_err <= 1'b1;
        end
        pack_r[eff_idx_s] <= comp_s;
        if (eff_idx_s == IDX_ZERO) begin
          sof_pend_r <= rgb_sof;
        end
        if (eff_idx_s == IDX_LAST) begin
          pix_idx_r <= IDX_ZERO;
          raw_out   <= word_s;
          raw_valid <= 1'b1;
          raw_sof   <= ONE_LANE ? rgb_sof : sof_pend_r;
          raw_eol   <= (eff_x_s == X_LAST);
        end else begin
          pix_idx_r <= eff_idx_s + IW'(1);
          if (raw_valid && raw_ready) begin
            raw_valid <= 1'b0;
          end
        end
        if (eff_x_s == X_LAST) begin
          x_r   <= {XW{1'b0}};
          row_r <= ~eff_row_s;
        end else begin
          x_r   <= eff_x_s + XW'(1);
          row_r <= eff_row_s;
        end
      end else if (raw_valid && raw_ready) begin
        raw_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb2raw.sv
// Scoreboard bench for rgb2raw: an RGGB instance with 8-pixel lines for the
// directed cases and a BGGR instance with 640-pixel lines for the random stream.
`timescale 1ns/1ps
module tb_rgb2raw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [23:0] rgb_in    [2];
  logic        rgb_valid [2];
  logic        rgb_sof   [2];
  logic        rgb_ready [2];
  logic [31:0] raw_out   [2];
  logic        raw_valid [2];
  logic        raw_sof   [2];
  logic        raw_eol   [2];
  logic        raw_ready [2];
  logic        frame_err [2];

  rgb2raw #(.LINE_LENGTH(8), .RGB_WIDTH(24), .PIX_PER_WORD(4), .BAYER_PATTERN(0)) u_dut_a (
    .clk(clk), .rst(rst), .rgb_in(rgb_in[0]), .rgb_valid(rgb_valid[0]), .rgb_sof(rgb_sof[0]),
    .rgb_ready(rgb_ready[0]), .raw_out(raw_out[0]), .raw_valid(raw_valid[0]), .raw_sof(raw_sof[0]),
    .raw_eol(raw_eol[0]), .raw_ready(raw_ready[0]), .frame_err(frame_err[0]));

  rgb2raw #(.LINE_LENGTH(640), .RGB_WIDTH(24), .PIX_PER_WORD(4), .BAYER_PATTERN(3)) u_dut_b (
    .clk(clk), .rst(rst), .rgb_in(rgb_in[1]), .rgb_valid(rgb_valid[1]), .rgb_sof(rgb_sof[1]),
    .rgb_ready(rgb_ready[1]), .raw_out(raw_out[1]), .raw_valid(raw_valid[1]), .raw_sof(raw_sof[1]),
    .raw_eol(raw_eol[1]), .raw_ready(raw_ready[1]), .frame_err(frame_err[1]));

  typedef struct packed {
    logic [31:0] word;
    logic        sof;
    logic        eol;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   line_len [2] = '{8, 640};
  int   pat      [2] = '{0, 3};
  int   mx [2], mrow [2], midx [2];
  logic [7:0] mpack [2][4];
  logic       msof  [2];
  bit   rnd_ready = 1'b0;
  bit   count_b   = 1'b0;
  int   words_b   = 0;
  int   eols_b    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] px(input int k);
    logic [7:0] kk;
    kk = 8'(k);
    return {8'h10 + kk, 8'h20 + kk, 8'h30 + kk};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mx[d] = 0; mrow[d] = 0; midx[d] = 0; msof[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_accept(input int d, input logic [23:0] p, input logic s);
    int x, r, i, ph;
    logic [7:0] c;
    exp_t e;
    x = mx[d]; r = mrow[d]; i = midx[d];
    if (s) begin
      x = 0; r = 0; i = 0;
    end
    ph = ((r * 2) + (x % 2)) ^ pat[d];
    if (ph == 0)      c = p[23:16];
    else if (ph == 3) c = p[7:0];
    else              c = p[15:8];
    mpack[d][i] = c;
    if (i == 0) msof[d] = s;
    if (i == 3) begin
      e.word = {mpack[d][3], mpack[d][2], mpack[d][1], mpack[d][0]};
      e.sof  = msof[d];
      e.eol  = (x == line_len[d] - 1);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      i = 0;
    end else begin
      i++;
    end
    if (x == line_len[d] - 1) begin
      x = 0; r = 1 - r;
    end else begin
      x++;
    end
    mx[d] = x; mrow[d] = r; midx[d] = i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) raw_ready[1] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive(input int d, input logic [23:0] p, input logic s);
    bit done;
    done = 1'b0;
    rgb_in[d] = p; rgb_sof[d] = s; rgb_valid[d] = 1'b1;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (rgb_ready[d]) begin
        model_accept(d, p, s);
        done = 1'b1;
      end
      tick();
    end
    check($sformatf("drive_accepted[%0d]", d), 32'(done), 32'd1);
    rgb_valid[d] = 1'b0; rgb_sof[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check_word(input int d, input logic [31:0] w, input logic s, input logic e);
    check($sformatf("latency_valid[%0d]", d), 32'(raw_valid[d]), 32'd1);
    check($sformatf("word[%0d]", d), raw_out[d], w);
    check($sformatf("word_sof[%0d]", d), 32'(raw_sof[d]), 32'(s));
    check($sformatf("word_eol[%0d]", d), 32'(raw_eol[d]), 32'(e));
  endtask

  // Scoreboard: every handshaked output word is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    int   qs;
    for (int d = 0; d < 2; d++) begin
      if (!rst && raw_valid[d] && raw_ready[d]) begin
        qs = (d == 0) ? q0.size() : q1.size();
        check($sformatf("word_expected[%0d]", d), 32'(qs > 0), 32'd1);
        if (qs > 0) begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("sb_word[%0d]", d), raw_out[d], e.word);
          check($sformatf("sb_sof[%0d]", d), 32'(raw_sof[d]), 32'(e.sof));
          check($sformatf("sb_eol[%0d]", d), 32'(raw_eol[d]), 32'(e.eol));
        end
        if (d == 1 && count_b) begin
          words_b++;
          if (raw_eol[1]) eols_b++;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rgb_in[d] = 24'h0; rgb_valid[d] = 1'b0; rgb_sof[d] = 1'b0; raw_ready[d] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("rst_raw_valid", 32'(raw_valid[0]), 32'd0);
    check("rst_raw_out", raw_out[0], 32'h0);
    check("rst_raw_sof", 32'(raw_sof[0]), 32'd0);
    check("rst_raw_eol", 32'(raw_eol[0]), 32'd0);
    check("rst_frame_err", 32'(frame_err[0]), 32'd0);
    check("rst_rgb_ready", 32'(rgb_ready[0]), 32'd1);
    check("rst_raw_valid_b", 32'(raw_valid[1]), 32'd0);

    // Line 0, RGGB, with an ignored sof while rgb_valid is low.
    drive(0, px(0), 1'b1);
    drive(0, px(1), 1'b0);
    rgb_sof[0] = 1'b1;
    tick();
    rgb_sof[0] = 1'b0;
    drive(0, px(2), 1'b0);
    drive(0, px(3), 1'b0);
    check_word(0, 32'h23122110, 1'b1, 1'b0);
    for (int k = 4; k < 8; k++) drive(0, px(k), 1'b0);
    check_word(0, 32'h27162514, 1'b0, 1'b1);

    // Line 1: G/B alternation.
    for (int k = 0; k < 4; k++) drive(0, px(k), 1'b0);
    check_word(0, 32'h33223120, 1'b0, 1'b0);
    for (int k = 4; k < 8; k++) drive(0, px(k), 1'b0);
    check_word(0, 32'h37263524, 1'b0, 1'b1);
    idle(2);

    // Backpressure: word 0 held, the 8th pixel stalls.
    raw_ready[0] = 1'b0;
    drive(0, px(0), 1'b1);
    for (int k = 1; k < 7; k++) drive(0, px(k), 1'b0);
    rgb_in[0] = px(7); rgb_valid[0] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("stall_rgb_ready", 32'(rgb_ready[0]), 32'd0);
      check("stall_raw_valid", 32'(raw_valid[0]), 32'd1);
      check("stall_hold_word", raw_out[0], 32'h23122110);
      check("stall_hold_sof", 32'(raw_sof[0]), 32'd1);
      @(posedge clk);
      #1;
    end
    raw_ready[0] = 1'b1;
    drive(0, px(7), 1'b0);
    check_word(0, 32'h27162514, 1'b0, 1'b1);
    idle(2);
    check("no_duplicate", 32'(raw_valid[0]), 32'd0);

    // Sof on the 3rd pixel of a word.
    drive(0, px(8), 1'b0);
    drive(0, px(9), 1'b0);
    check("pre_sof_frame_err", 32'(frame_err[0]), 32'd0);
    drive(0, px(0), 1'b1);
    check("sof_mid_frame_err", 32'(frame_err[0]), 32'd1);
    for (int k = 1; k < 4; k++) drive(0, px(k), 1'b0);
    check_word(0, 32'h23122110, 1'b1, 1'b0);
    for (int k = 4; k < 8; k++) drive(0, px(k), 1'b0);
    idle(2);
    check("frame_err_sticky", 32'(frame_err[0]), 32'd1);

    // Reset while a word is stalled.
    raw_ready[0] = 1'b0;
    drive(0, px(0), 1'b1);
    for (int k = 1; k < 4; k++) drive(0, px(k), 1'b0);
    check("held_before_rst", 32'(raw_valid[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("rst_stall_raw_valid", 32'(raw_valid[0]), 32'd0);
    check("rst_stall_frame_err", 32'(frame_err[0]), 32'd0);
    check("rst_stall_rgb_ready", 32'(rgb_ready[0]), 32'd1);
    raw_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) drive(0, px(k), 1'b0);
    check_word(0, 32'h23122110, 1'b0, 1'b0);
    idle(2);

    // BGGR on the 640-pixel instance: both rows.
    drive(1, px(0), 1'b1);
    for (int k = 1; k < 4; k++) drive(1, px(k), 1'b0);
    check_word(1, 32'h23322130, 1'b1, 1'b0);
    for (int k = 4; k < 640; k++) drive(1, px(k), 1'b0);
    for (int k = 0; k < 4; k++) drive(1, px(k), 1'b0);
    check_word(1, 32'h13221120, 1'b0, 1'b0);
    idle(2);

    // Two random frames of 640x4 with random valid gaps and backpressure.
    count_b = 1'b1;
    rnd_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 4; l++) begin
        for (int x = 0; x < 640; x++) begin
          drive(1, 24'($urandom), (x == 0 && l == 0));
          if ($urandom_range(0, 3) == 0) tick();
        end
      end
    end
    rnd_ready = 1'b0;
    raw_ready[1] = 1'b1;
    idle(4);
    count_b = 1'b0;
    check("long_words", 32'(words_b), 32'd1280);
    check("long_eols", 32'(eols_b), 32'd8);
    check("long_frame_err", 32'(frame_err[1]), 32'd0);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
